// File: rtl/mmul_drain.sv
// Drains one order x order result matrix from a first-word-fall-through FIFO onto a
// valid/ready stream. Optional trailing checksum beat when MMUL_DRAIN_CHECKSUM_EN is defined.
module mmul_drain #(
    parameter int order         = 64,
    parameter int counter_width = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        Done,
    input  logic        fC_read_ready,
    output logic        fC_read_enable,
    input  logic [31:0] fC_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last_row,
    output logic        out_last,
    output logic        out_is_sum
);

    typedef enum logic [1:0] {IDLE, STREAM, SUM, FINISH} state_t;

    localparam logic [counter_width-1:0] LAST_IDX = counter_width'(order - 1);

    state_t                   state_r, state_s;
    logic [counter_width-1:0] col_r, row_r;
    logic                     all_popped_r;
    logic                     final_beat_r;
    logic                     done_r;
    logic                     out_valid_r, last_row_r, last_r, is_sum_r;
    logic [31:0]              data_r;
    logic                     pop_s, accept_s, last_word_s, start_s;
`ifdef MMUL_DRAIN_CHECKSUM_EN
    logic [31:0]              sum_r;
`endif

    assign fC_read_enable = pop_s;
    assign Done           = done_r;
    assign out_valid      = out_valid_r;
    assign out_data       = data_r;
    assign out_last_row   = last_row_r;
    assign out_last       = last_r;
    assign out_is_sum     = is_sum_r;

    // Pop/accept handshakes and next-state selection.
    always_comb begin
        accept_s    = out_valid_r & out_ready;
        start_s     = (state_r == IDLE) & START;
        last_word_s = (row_r == LAST_IDX) & (col_r == LAST_IDX);
        pop_s       = ~RST & (state_r == STREAM) & fC_read_ready & ~all_popped_r
                      & (~out_valid_r | out_ready);
        state_s     = state_r;
        case (state_r)
            IDLE: begin
                if (START) state_s = STREAM;
                else       state_s = IDLE;
            end
            STREAM: begin
                if (accept_s && final_beat_r) begin
`ifdef MMUL_DRAIN_CHECKSUM_EN
                    state_s = SUM;
`else
                    state_s = FINISH;
`endif
                end else begin
                    state_s = STREAM;
                end
            end
            SUM: begin
                if (accept_s) state_s = FINISH;
                else          state_s = SUM;
            end
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, position counters, running checksum and Done flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            col_r        <= '0;
            row_r        <= '0;
            all_popped_r <= 1'b0;
            done_r       <= 1'b0;
`ifdef MMUL_DRAIN_CHECKSUM_EN
            sum_r        <= 32'd0;
`endif
        end else begin
            state_r <= state_s;
            if (start_s) begin
                col_r        <= '0;
                row_r        <= '0;
                all_popped_r <= 1'b0;
`ifdef MMUL_DRAIN_CHECKSUM_EN
                sum_r        <= 32'd0;
`endif
            end else if (pop_s) begin
                all_popped_r <= last_word_s;
`ifdef MMUL_DRAIN_CHECKSUM_EN
                sum_r        <= sum_r + fC_read_data;
`endif
                if (col_r == LAST_IDX) begin
                    col_r <= '0;
                    row_r <= (row_r == LAST_IDX) ? '0 : row_r + 1'b1;
                end else begin
                    col_r <= col_r + 1'b1;
                end
            end
            if (start_s)                   done_r <= 1'b0;
            else if (state_s == FINISH)    done_r <= 1'b1;
        end
    end

    // One-entry output register: reload on pop, swap in the checksum after the last data beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_r  <= 1'b0;
            data_r       <= 32'd0;
            last_row_r   <= 1'b0;
            last_r       <= 1'b0;
            is_sum_r     <= 1'b0;
            final_beat_r <= 1'b0;
        end else if (pop_s) begin
            out_valid_r  <= 1'b1;
            data_r       <= fC_read_data;
            last_row_r   <= (col_r == LAST_IDX);
`ifdef MMUL_DRAIN_CHECKSUM_EN
            last_r       <= 1'b0;
`else
            last_r       <= last_word_s;
`endif
            is_sum_r     <= 1'b0;
            final_beat_r <= last_word_s;
        end else if (accept_s && final_beat_r && (state_r == STREAM)) begin
`ifdef MMUL_DRAIN_CHECKSUM_EN
            out_valid_r  <= 1'b1;
            data_r       <= sum_r;
            last_row_r   <= 1'b0;
            last_r       <= 1'b1;
            is_sum_r     <= 1'b1;
`else
            out_valid_r  <= 1'b0;
`endif
            final_beat_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b0;
            final_beat_r <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_mmul_drain.sv
// Directed bench for mmul_drain with order=4; expectations adapt to MMUL_DRAIN_CHECKSUM_EN.
module tb_mmul_drain;

    logic        CLK = 1'b0;
    logic        RST, START, Done;
    logic        fC_read_ready, fC_read_enable, out_valid, out_ready;
    logic [31:0] fC_read_data, out_data;
    logic        out_last_row, out_last, out_is_sum;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pops     = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] bd[$];
    logic [2:0]  bf[$];
    logic [31:0] exp_words[16];

    mmul_drain #(.order(4), .counter_width(2)) dut (
        .CLK(CLK), .RST(RST), .START(START), .Done(Done),
        .fC_read_ready(fC_read_ready), .fC_read_enable(fC_read_enable),
        .fC_read_data(fC_read_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last_row(out_last_row), .out_last(out_last),
        .out_is_sum(out_is_sum)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic load_fifo(input int kind);
        fifo_q.delete();
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0:       exp_words[i] = 32'(i + 1);
                1:       exp_words[i] = 32'h1000_0000 + 32'(i * 3);
                2:       exp_words[i] = 32'hFFFF_FFFF;
                default: exp_words[i] = 32'(101 + i);
            endcase
            fifo_q.push_back(exp_words[i]);
        end
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hDEAD_0000 + 32'(i));
    endtask

    task automatic start_matrix();
        @(negedge CLK);
        START = 1'b1;
        fC_read_ready = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        pops = 0;
        bd.delete();
        bf.delete();
        chk("done_cleared", 32'(Done), 32'd0);
    endtask

    // mode 0: sink always ready, 1: sink toggles, 2: FIFO empty 5 cycles after word 7
    task automatic run_cycles(input int mode, input int stop_beats, input int budget);
        int          cyc = 0;
        int          stall_left = 0;
        bit          stalled = 0;
        bit          held_v = 0;
        bit          popping;
        logic [31:0] held_d;
        while (cyc < budget && !(stop_beats > 0 && bd.size() >= stop_beats)
               && !(stop_beats == 0 && Done === 1'b1)) begin
            @(negedge CLK);
            out_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            if (mode == 2 && pops == 7 && !stalled) begin
                stalled = 1;
                stall_left = 5;
            end
            fC_read_ready = (stall_left == 0) && (fifo_q.size() > 0);
            fC_read_data  = fC_read_ready ? fifo_q[0] : 32'h0;
            if (stall_left > 0) stall_left--;
            #1;
            if (held_v) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", out_data, held_d);
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (out_valid && out_ready) begin
                bd.push_back(out_data);
                bf.push_back({out_last_row, out_last, out_is_sum});
            end
            popping = fC_read_enable;
            @(posedge CLK); #1;
            if (popping) begin
                void'(fifo_q.pop_front());
                pops++;
            end
            cyc++;
        end
        @(negedge CLK);
        fC_read_ready = 1'b0;
        out_ready = 1'b0;
        chk("no_timeout", 32'(cyc < budget), 32'd1);
    endtask

    task automatic verify_matrix();
        logic [31:0] sum = 32'd0;
        int          n_exp = 16;
`ifdef MMUL_DRAIN_CHECKSUM_EN
        n_exp = 17;
`endif
        for (int i = 0; i < 16; i++) sum += exp_words[i];
        chk("beat_count", 32'(bd.size()), 32'(n_exp));
        for (int i = 0; i < 16 && i < bd.size(); i++) begin
            chk("beat_data", bd[i], exp_words[i]);
            chk("beat_last_row", 32'(bf[i][2]), 32'((i % 4) == 3));
`ifdef MMUL_DRAIN_CHECKSUM_EN
            chk("beat_last", 32'(bf[i][1]), 32'd0);
`else
            chk("beat_last", 32'(bf[i][1]), 32'(i == 15));
`endif
            chk("beat_is_sum", 32'(bf[i][0]), 32'd0);
        end
`ifdef MMUL_DRAIN_CHECKSUM_EN
        if (bd.size() == 17) begin
            chk("sum_data", bd[16], sum);
            chk("sum_flags", 32'(bf[16]), 32'b011);
        end
`endif
        chk("pop_count", 32'(pops), 32'd16);
        chk("fifo_left", 32'(fifo_q.size()), 32'd4);
        chk("done_set", 32'(Done), 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        chk("done_held", 32'(Done), 32'd1);
        chk("idle_no_pop", 32'(fC_read_enable), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        out_ready = 1'b0;
        fC_read_ready = 1'b0;
        fC_read_data = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_flags", 32'({out_last_row, out_last, out_is_sum}), 32'd0);
        chk("rst_pop", 32'(fC_read_enable), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        load_fifo(0); start_matrix(); run_cycles(0, 0, 200); verify_matrix();
        load_fifo(1); start_matrix(); run_cycles(1, 0, 200); verify_matrix();
        load_fifo(0); start_matrix(); run_cycles(2, 0, 200); verify_matrix();
        load_fifo(2); start_matrix(); run_cycles(0, 0, 200); verify_matrix();

        // abort mid-matrix with reset, then a fresh matrix must start at row 0 col 0
        load_fifo(0); start_matrix(); run_cycles(0, 5, 200);
        @(negedge CLK);
        RST = 1'b1;
        fC_read_ready = 1'b1;
        fC_read_data = 32'h5555_5555;
        #1;
        chk("abort_no_pop", 32'(fC_read_enable), 32'd0);
        @(posedge CLK); #1;
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_data", out_data, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        fC_read_ready = 1'b0;
        #1;
        chk("after_abort_no_pop", 32'(fC_read_enable), 32'd0);
        load_fifo(3); start_matrix(); run_cycles(0, 0, 200); verify_matrix();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mmul_drain.md
MMUL_DRAIN -- requirements
Module: mmul_drain

Interface
REQ-001 SHALL have parameter: order, default 64, matrix dimension; one matrix = order*order words.
REQ-002 SHALL have parameter: counter_width, default 6, width of row/col counters, $clog2(order).
REQ-003 SHALL have port: CLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port: RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: START  input  1  begin draining one result matrix.
REQ-006 SHALL have port: Done  output  1  matrix fully delivered, level.
REQ-007 SHALL have port: fC_read_ready  input  1  upstream result FIFO non-empty.
REQ-008 SHALL have port: fC_read_enable  output  1  pop upstream FIFO this cycle.
REQ-009 SHALL have port: fC_read_data  input  32  head word of upstream FIFO, valid while fC_read_ready=1 (first-word-fall-through).
REQ-010 SHALL have port: out_valid  output  1  out_data holds a beat.
REQ-011 SHALL have port: out_ready  input  1  sink accepts beat when out_valid=1.
REQ-012 SHALL have port: out_data  output  32  result element or checksum.
REQ-013 SHALL have port: out_last_row  output  1  beat is last column of a row.
REQ-014 SHALL have port: out_last  output  1  final beat of the matrix transfer.
REQ-015 SHALL have port: out_is_sum  output  1  beat carries the checksum.

Function
REQ-016 SHALL use states IDLE, STREAM, SUM, FINISH; IDLE->STREAM on START=1; START ignored outside IDLE.
REQ-017 SHALL hold a one-entry output register; a beat is accepted when out_valid=1 and out_ready=1.
REQ-018 SHALL assert fC_read_enable combinationally only when state=STREAM, fC_read_ready=1, elements popped < order*order, and output register empty or being accepted in the same cycle.
REQ-019 SHALL load fC_read_data into the output register on the popping edge; out_valid rises 1 cycle after the pop (latency 1).
REQ-020 SHALL sustain 1 word/cycle when fC_read_ready=1 and out_ready=1 continuously (simultaneous accept and reload).
REQ-021 SHALL keep out_data/flags stable while out_valid=1 and out_ready=0.
REQ-022 SHALL stall without loss when fC_read_ready drops mid-stream; out_valid falls after acceptance if no new pop.
REQ-023 SHALL track col 0..order-1 and row 0..order-1 per popped word, col wrapping to 0 and incrementing row; out_last_row=1 when col=order-1.
REQ-024 SHALL, after the final data beat (row=col=order-1) is accepted, go to SUM when CHECKSUM_EN is defined, else FINISH.
REQ-025 SHALL in FINISH set Done=1 and return to IDLE next cycle; Done stays 1 until the next accepted START, which clears it.
REQ-026 SHALL pop exactly order*order words per matrix, never more.

Reset
REQ-027 SHALL on RST=1 force state=IDLE, Done=0, out_valid=0, out_data=0, all flags=0, counters and checksum=0, fC_read_enable=0.
REQ-028 SHALL abort any in-progress transfer on RST mid-operation; partially delivered matrix is discarded, no further pops.

Configuration
REQ-029 SHALL support macro MMUL_DRAIN_CHECKSUM_EN.
REQ-030 SHALL, with MMUL_DRAIN_CHECKSUM_EN defined, accumulate a 32-bit wrapping sum of popped words; final data beat has out_last=0; SUM state emits one beat out_data=sum, out_is_sum=1, out_last=1, out_last_row=0, then FINISH after acceptance.
REQ-031 SHALL, without the macro, omit the accumulator and SUM state; final data beat has out_last=1; out_is_sum tied 0.

Verification (order=4)
REQ-032 SHALL cover: reset, START, FIFO supplies 1..16, out_ready=1 -> 16 beats 1..16 back-to-back, out_last_row on 4,8,12,16, Done=1 after end.
REQ-033 SHALL cover: out_ready toggling every other cycle -> no loss/duplication, data held stable during stalls, exactly 16 pops.
REQ-034 SHALL cover: fC_read_ready=0 for 5 cycles after word 7 -> output pauses, resumes at 8, order preserved.
REQ-035 SHALL cover: MMUL_DRAIN_CHECKSUM_EN defined, words 1..16 -> 17th beat out_data=136, out_is_sum=1, out_last=1; word 16 has out_last=0.
REQ-036 SHALL cover: words 0xFFFFFFFF x16 with checksum -> sum beat 0xFFFFFFF0 (wrap).
REQ-037 SHALL cover: RST asserted after beat 5 then new START -> Done=0, next matrix begins at row 0 col 0, 16 fresh pops.
